dual_port_reg_file: RTL and testbench



---
 rtl/dual_port_reg_file.sv | 123 ++++++++++++
 tb/tb_dual_port_reg_file.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dual_port_reg_file.sv
// Dual-port register file: one write port with byte enables, one registered read port, hardware zero sweep.
// Optional macro DUAL_PORT_REG_FILE_BYPASS_EN selects write-first on a same-address read/write (default read-first).
module dual_port_reg_file #(
    parameter int    B    = 16,
    parameter int    W    = 11,
    parameter string FILE = ""
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           wr_en,
    input  logic [W-1:0]   wr_addr,
    input  logic [B/8-1:0] wr_be,
    input  logic [B-1:0]   w_data,
    input  logic           rd_en,
    input  logic [W-1:0]   rd_addr,
    output logic [B-1:0]   r_data,
    output logic           r_valid,
    output logic           busy
);
    localparam int NB             = B / 8;
    localparam int DEPTH          = 2 ** W;
    localparam bit SWEEP_AT_RESET = (FILE == "");

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic [W-1:0]    cnt;
    logic [B-1:0]    mem [DEPTH];

    logic            user_wr;
    logic            user_rd;
    logic [NB-1:0]   port_be;
    logic [W-1:0]    port_addr;
    logic [B-1:0]    port_data;
    logic [B-1:0]    rd_word;

    assign busy    = (state == CLEAR);
    // clr in the same cycle as a write wins and the write is dropped.
    assign user_wr = !busy && wr_en && !clr;
    assign user_rd = !busy && rd_en;

    // The sweep and the user write share the single physical write port.
    always_comb begin
        port_be   = '0;
        port_addr = wr_addr;
        port_data = w_data;
        if (!rst_n) begin
            port_be = '0;
        end else if (busy) begin
            port_be   = '1;
            port_addr = cnt;
            port_data = '0;
        end else if (user_wr) begin
            port_be = wr_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SWEEP_AT_RESET ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    // Terminal compare keeps the W-bit counter from wrapping into a second pass.
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == W'(DEPTH - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (port_be[i]) begin
                mem[port_addr][8*i +: 8] <= port_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef DUAL_PORT_REG_FILE_BYPASS_EN
        if (user_wr && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = w_data[8*i +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= user_rd;
            if (user_rd) begin
                r_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_reg_file.sv
// Bench for dual_port_reg_file (B=16, W=4): directed scenarios plus random traffic against an array model.
module tb_dual_port_reg_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [1:0]  wr_be = '0;
    logic [15:0] w_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] r_data;
    logic        r_valid;
    logic        busy;

    // Reference state: word array, remaining sweep cycles, expected read outputs.
    logic [15:0] ref_mem [16];
    int          sweep_left = 0;
    logic [15:0] exp_data = '0;
    logic        exp_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          busy_cnt;

    dual_port_reg_file #(.B(16), .W(4), .FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .w_data(w_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .r_data(r_data), .r_valid(r_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One clock: drive, advance to the edge, update the model, check #1 later.
    task automatic step(input logic c, input logic we, input logic [3:0] wa, input logic [1:0] be,
                        input logic [15:0] wd, input logic re, input logic [3:0] ra);
        clr = c; wr_en = we; wr_addr = wa; wr_be = be; w_data = wd; rd_en = re; rd_addr = ra;
        @(posedge clk);
        if (sweep_left > 0) begin
            exp_valid = 1'b0;
            if (c) sweep_left = 16;
            else   sweep_left = sweep_left - 1;
            if (sweep_left == 0) begin
                for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
            end
        end else begin
            exp_valid = re;
            if (re) begin
                exp_data = ref_mem[ra];
`ifdef DUAL_PORT_REG_FILE_BYPASS_EN
                if (we && !c && wa == ra) exp_data = merge(ref_mem[ra], wd, be);
`endif
            end
            if (we && !c) ref_mem[wa] = merge(ref_mem[wa], wd, be);
            if (c) sweep_left = 16;
        end
        #1;
        check("busy", {15'd0, busy}, {15'd0, sweep_left > 0});
        check("r_valid", {15'd0, r_valid}, {15'd0, exp_valid});
        check("r_data", r_data, exp_data);
    endtask

    task automatic rand_step(input int clr_pct);
        logic [3:0] wa;
        logic [3:0] ra;
        wa = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
        step($urandom_range(0, 99) < clr_pct, 1'($urandom_range(0, 1)), wa,
             2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)), ra);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        #1;
        check("rst_r_data", r_data, 16'h0000);
        check("rst_r_valid", {15'd0, r_valid}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0001);
        exp_data = '0; exp_valid = 1'b0; sweep_left = 16;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_read(input logic [3:0] a);
        step(1'b0, 1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, a);
    endtask

    task automatic idle_write(input logic [3:0] a, input logic [1:0] be, input logic [15:0] d);
        step(1'b0, 1'b1, a, be, d, 1'b0, 4'd0);
    endtask

    initial begin
        // Power-up reset: exactly 16 busy cycles, random traffic ignored meanwhile.
        apply_reset();
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            rand_step(0);
            if (busy === 1'b1) busy_cnt++;
        end
        check("reset_sweep_len", 16'(busy_cnt), 16'd16);

        for (int a = 0; a < 16; a++) idle_read(4'(a));

        // Byte-masked read-modify-write.
        idle_write(4'd3, 2'b11, 16'hABCD);
        idle_write(4'd3, 2'b01, 16'h1234);
        idle_read(4'd3);
        check("rmw_a3", r_data, 16'hAB34);

        // Same-address read and write in one cycle.
        idle_write(4'd5, 2'b11, 16'h1111);
        step(1'b0, 1'b1, 4'd5, 2'b10, 16'h2222, 1'b1, 4'd5);
`ifdef DUAL_PORT_REG_FILE_BYPASS_EN
        check("collide_a5", r_data, 16'h2211);
`else
        check("collide_a5", r_data, 16'h1111);
`endif
        idle_read(4'd5);
        check("after_collide_a5", r_data, 16'h2211);

        for (int i = 0; i < 300; i++) rand_step(3);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);

        // clr restarted on the 4th busy cycle: 4 + 16 busy cycles.
        idle_write(4'd9, 2'b11, 16'h5A5A);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 0 || i == 4) step(1'b1, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
            else rand_step(0);
            if (busy === 1'b1) busy_cnt++;
        end
        check("restart_sweep_len", 16'(busy_cnt), 16'd20);
        idle_read(4'd9);

        // clr together with a write: write dropped.
        step(1'b1, 1'b1, 4'd7, 2'b11, 16'hFFFF, 1'b0, 4'd0);
        for (int i = 0; i < 17; i++) rand_step(0);
        idle_read(4'd7);
        check("clr_drops_write", r_data, 16'h0000);

        // Reset mid-sweep clears outputs at once, then a full sweep runs.
        idle_write(4'd9, 2'b11, 16'hBEEF);
        idle_read(4'd9);
        check("pre_reset_read", r_data, 16'hBEEF);
        step(1'b1, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) rand_step(0);
        apply_reset();
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            rand_step(0);
            if (busy === 1'b1) busy_cnt++;
        end
        check("midsweep_reset_len", 16'(busy_cnt), 16'd16);
        idle_read(4'd9);

        for (int i = 0; i < 200; i++) rand_step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
